spi_flash_boot_reader: RTL and testbench
========================================

Name: spi_flash_boot_reader

Overview:
- Hardware SPI-flash read engine for the SPI bootloader. It sits between the board's SPI flash pins and the boot-copy logic that writes into MicroBlaze memory.
- On a start request it issues a standard READ (0x03) command with a 24-bit address. It then streams the requested number of bytes out on a valid/ready byte interface, with back-pressure.
- It runs alongside the AXI Quad SPI core, so boot images are fetched without processor involvement.

Parameters:
- CLK_DIV, 2: CLOCK cycles per SCK half-period; legal range 1..255.
- LEN_W, 16: width of the byte-count input.

Ports:
- CLOCK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- start_addr  in  24  flash byte address of the first byte.
- length  in  LEN_W  number of bytes to read; 0 means no transfer.
- busy  out  1  high from start acceptance until the done pulse, inclusive.
- done  out  1  one-cycle pulse when the transfer is complete.
- byte_data  out  8  received byte, MSB first on the wire.
- byte_valid  out  1  byte_data is valid; held until accepted.
- byte_ready  in  1  consumer accepts the byte when byte_valid & byte_ready.
- spi_sck  out  1  SPI clock, mode 0 (idles low).
- spi_ss_n  out  1  flash chip select, active-low.
- spi_mosi  out  1  command/address serial out.
- spi_miso  in  1  data serial in.

Behaviour:
- Reset values (asynchronous, immediate, including mid-transfer): spi_ss_n=1, spi_sck=0, spi_mosi=0, busy=0, done=0, byte_valid=0, byte_data=0. The FSM returns to IDLE.
- State machine: IDLE -> SEL -> CMD -> ADDR -> DATA -> DESEL -> DONE -> IDLE.
- IDLE:
  - start=1 with length!=0: latch start_addr and length, set busy=1, go to SEL.
  - start=1 with length==0: go directly to DONE. busy=1 for one cycle together with done; spi_ss_n never asserts.
- SEL: spi_ss_n=0. Wait CLK_DIV cycles (CS setup), then go to CMD.
- SCK timing: a divider tick fires every CLK_DIV cycles and each tick toggles spi_sck.
- Bit shifting:
  - spi_mosi is updated while SCK is low, before each rising edge, MSB first.
  - spi_miso is sampled on the cycle SCK rises.
- CMD shifts 8 bits of 0x03. ADDR shifts 24 address bits. Total is 32 SCK rising edges; spi_mosi=0 afterwards.
- DATA: 8 rising edges per byte.
  - On the 8th sample, the shift register is copied to byte_data, byte_valid is set the next cycle, and the remaining count is decremented.
  - Shifting of the next byte continues immediately.
- Back-pressure: if byte_valid is still 1 when the next byte is about to take its 8th rising edge, SCK is held low. Ticks are suppressed and no edge is lost. SCK restarts on the tick following acceptance.
- Data is never overwritten or dropped.
- Simultaneous accept and new-byte capture in the same cycle: byte_valid stays 1 and byte_data takes the new byte.
- After the last byte is captured:
  - SCK stays low and the FSM enters DESEL.
  - DESEL waits for the final byte to be accepted, then drives spi_ss_n=1 and holds it for CLK_DIV cycles (minimum deselect).
  - DONE: done=1 for exactly one cycle, busy drops on the following cycle.
- start while busy is ignored; inputs are not re-sampled.
- The address is not incremented by this block; the flash auto-increments. Reads past 0xFFFFFF wrap inside the flash, and this block does not check for it.
- Unstalled transfer duration for length L:
  - (32+8L)*2*CLK_DIV + about 3*CLK_DIV cycles from start to done.
  - First SCK rise is CLK_DIV cycles after spi_ss_n falls.

Decomposition:
- Shared package spi_boot_pkg contains:
  - localparam SPI_CMD_READ = 8'h03;
  - ADDR_W = 24;
  - the FSM state enum (IDLE, SEL, CMD, ADDR, DATA, DESEL, DONE).
- One sub-module, spi_sck_gen:
  - CLK_DIV counter producing a tick, with enable/stall input;
  - SCK toggle, with rise/fall strobes to the parent.
- The parent owns the FSM, the 32-bit TX shift register, the 8-bit RX shift register, the byte counter and the output register.

Test Plan:
- CLK_DIV=2, start_addr=0x012345, length=4, flash model returns 0xA0..0xA3, byte_ready=1:
  - MOSI bitstream is 0x03 then 0x012345;
  - bytes arrive as A0, A1, A2, A3;
  - 64 rising SCK edges occur;
  - done is a single pulse and spi_ss_n is high before done.
- Same transfer with byte_ready low for 50 cycles after the first byte:
  - SCK freezes low before the 8th edge of byte 2;
  - no data loss; order is A0..A3;
  - byte_data is stable while stalled.
- length=0:
  - done pulses one cycle after start;
  - spi_ss_n stays 1 and no SCK edges occur.
- RESET asserted mid-ADDR phase:
  - same cycle: spi_ss_n=1, spi_sck=0, busy=0;
  - a subsequent start with length=1 completes normally.
- start pulsed again during DATA with a different address: ignored; the transfer completes with the original address and length.
- CLK_DIV=1, length=256, random byte_ready:
  - all 256 bytes match the flash model;
  - exactly 2080 rising SCK edges occur.

Source files
------------

// File: rtl/spi_flash_boot_reader_pkg.sv
// spi_boot_pkg: shared constants and FSM state type for the SPI flash boot reader
package spi_boot_pkg;
    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int ADDR_W = 24;
    typedef enum logic [2:0] {IDLE, SEL, CMD, ADDR, DATA, DESEL, DONE} state_t;
endpackage

// File: rtl/spi_flash_boot_reader_if.sv
// spi_flash_boot_reader_if: start request and byte stream between boot-copy logic and the reader
interface spi_flash_boot_reader_if import spi_boot_pkg::*; #(parameter int LEN_W = 16) ();
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    modport master(output start, start_addr, length, byte_ready, input busy, done, byte_data, byte_valid);
    modport slave(input start, start_addr, length, byte_ready, output busy, done, byte_data, byte_valid);
endinterface

// File: rtl/spi_flash_boot_reader_sck_gen.sv
// spi_sck_gen: divided mode-0 SCK with stall and one-cycle rise/fall strobes
module spi_sck_gen #(parameter int CLK_DIV = 2) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic stall,
    output logic sck,
    output logic rise,
    output logic fall
);
    localparam logic [7:0] TOP = 8'(CLK_DIV - 1);
    logic [7:0] cnt;
    logic       tick;
    always_comb begin
        tick = en && !stall && cnt == TOP;
        rise = tick && !sck;
        fall = tick && sck;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            sck <= 1'b0;
        end else begin
            cnt <= (!en || tick) ? 8'd0 : stall ? cnt : cnt + 8'd1;
            sck <= en && (sck ^ tick);
        end
endmodule

// File: rtl/spi_flash_boot_reader.sv
// spi_flash_boot_reader: issues READ 0x03 + 24-bit address and streams bytes out with back-pressure
module spi_flash_boot_reader import spi_boot_pkg::*; #(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 16
) (
    input  logic CLOCK,
    input  logic RESET,
    spi_flash_boot_reader_if.slave bus,
    output logic spi_sck,
    output logic spi_ss_n,
    output logic spi_mosi,
    input  logic spi_miso
);
    localparam logic [7:0] TOP = 8'(CLK_DIV - 1);
    state_t           state;
    logic [31:0]      tx;
    logic [7:0]       rx;
    logic [4:0]       bitn;
    logic [LEN_W-1:0] remaining;
    logic             last;
    logic [7:0]       wcnt;
    logic             run, stall, rise, fall, capture;
    always_comb begin
        run     = state inside {SEL, CMD, ADDR, DATA};
        // hold SCK low before the 8th edge while the previous byte is still unconsumed
        stall   = state == DATA && bitn[2:0] == 3'd7 && !spi_sck && bus.byte_valid && !bus.byte_ready;
        capture = state == DATA && rise && bitn[2:0] == 3'd7;
    end
    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk(CLOCK), .rst(RESET), .en(run), .stall(stall),
        .sck(spi_sck), .rise(rise), .fall(fall)
    );
    always_ff @(posedge CLOCK or posedge RESET)
        if (RESET) begin
            state          <= IDLE;
            tx             <= '0;
            rx             <= '0;
            bitn           <= '0;
            remaining      <= '0;
            last           <= 1'b0;
            wcnt           <= '0;
            spi_ss_n       <= 1'b1;
            spi_mosi       <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.byte_data  <= '0;
            bus.byte_valid <= 1'b0;
        end else begin
            if (fall) begin
                spi_mosi <= tx[31];
                tx       <= {tx[30:0], 1'b0};
            end
            if (rise) begin
                bitn <= bitn + 5'd1;
                rx   <= {rx[6:0], spi_miso};
            end
            if (capture) begin
                bus.byte_data <= {rx[6:0], spi_miso};
                remaining     <= remaining - LEN_W'(1);
                last          <= remaining == LEN_W'(1);
            end
            bus.byte_valid <= capture || (bus.byte_valid && !bus.byte_ready);
            case (state)
                IDLE: if (bus.start) begin
                    bus.busy <= 1'b1;
                    if (bus.length == '0) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state     <= SEL;
                        spi_ss_n  <= 1'b0;
                        spi_mosi  <= SPI_CMD_READ[7];
                        tx        <= {SPI_CMD_READ[6:0], bus.start_addr, 1'b0};
                        remaining <= bus.length;
                        bitn      <= '0;
                        last      <= 1'b0;
                    end
                end
                SEL:  if (rise) state <= CMD;
                CMD:  if (rise && bitn == 5'd7) state <= ADDR;
                ADDR: if (rise && bitn == 5'd31) state <= DATA;
                DATA: if (last && fall) begin
                    state <= DESEL;
                    wcnt  <= '0;
                end
                DESEL: if (!spi_ss_n) begin
                    if (!bus.byte_valid || bus.byte_ready) spi_ss_n <= 1'b1;
                end else begin
                    wcnt <= wcnt + 8'd1;
                    if (wcnt == TOP) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_spi_flash_boot_reader.sv
// tb_spi_flash_boot_reader: random-stimulus bench with a behavioural SPI flash and byte scoreboard
module tb_spi_flash_boot_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a [2];
    logic [23:0] addr_a  [2];
    logic [15:0] len_a   [2];
    logic        rdy_a   [2];
    logic        busy_a  [2];
    logic        done_a  [2];
    logic        valid_a [2];
    logic [7:0]  data_a  [2];
    logic        ss_a    [2];
    logic        sck_a   [2];
    logic        mosi_a  [2];
    int          rises_a [2];
    logic [31:0] cmd_a   [2];

    int ncmp = 0;
    int nerr = 0;
    int cur = 0;
    int mode = 0;
    bit cmp_on = 0;
    logic [7:0] expq[$];
    logic [7:0] got[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] fb(input logic [23:0] a);
        return a[7:0] + 8'h5B;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_flash_boot_reader_if #(.LEN_W(16)) b ();
        logic        sck_w, ss_w, mosi_w;
        logic        fmiso = 1'b0;
        int          fcnt = 0;
        int          rises_l = 0;
        logic [31:0] fca = '0;
        int          d;
        logic [7:0]  bt;
        assign b.start      = start_a[g];
        assign b.start_addr = addr_a[g];
        assign b.length     = len_a[g];
        assign b.byte_ready = rdy_a[g];
        assign busy_a[g]    = b.busy;
        assign done_a[g]    = b.done;
        assign valid_a[g]   = b.byte_valid;
        assign data_a[g]    = b.byte_data;
        assign ss_a[g]      = ss_w;
        assign sck_a[g]     = sck_w;
        assign mosi_a[g]    = mosi_w;
        assign rises_a[g]   = rises_l;
        assign cmd_a[g]     = fca;
        spi_flash_boot_reader #(.CLK_DIV(g == 0 ? 2 : 1), .LEN_W(16)) u (
            .CLOCK(clk), .RESET(rst), .bus(b),
            .spi_sck(sck_w), .spi_ss_n(ss_w), .spi_mosi(mosi_w), .spi_miso(fmiso)
        );
        always @(posedge sck_w) rises_l <= rises_l + 1;
        // flash: samples MOSI on rising SCK, presents the next data bit after each falling SCK
        always @(posedge sck_w or posedge ss_w)
            if (ss_w) fcnt <= 0;
            else begin
                if (fcnt < 32) fca <= {fca[30:0], mosi_w};
                fcnt <= fcnt + 1;
            end
        always @(negedge sck_w or posedge ss_w)
            if (ss_w) fmiso <= 1'b0;
            else if (fcnt >= 32) begin
                d = fcnt - 32;
                bt = fb(fca[23:0] + 24'(d / 8));
                fmiso <= bt[7 - d % 8];
            end
    end

    bit         hold_started = 0;
    int         hold = 0;
    int         stall_rises = 0;
    logic       stall_sck = 1'b1;
    logic       rnext;
    initial for (int i = 0; i < 2; i++) rdy_a[i] = 1'b1;
    always @(posedge clk) begin
        #1;
        if (mode != 1) hold_started = 0;
        else if (!hold_started && valid_a[cur]) begin
            hold_started = 1;
            hold = 50;
        end
        rnext = (mode == 2) ? ($urandom_range(0, 1) == 1) : (hold == 0);
        if (hold == 1) begin
            stall_rises = rises_a[cur];
            stall_sck = sck_a[cur];
        end
        if (hold > 0) hold--;
        for (int i = 0; i < 2; i++) rdy_a[i] = (i == cur) ? rnext : 1'b1;
    end

    logic       pv = 1'b0;
    logic       pacc = 1'b0;
    logic [7:0] pdata = '0;
    always @(negedge clk) if (cmp_on) begin
        if (valid_a[cur]) begin
            chk("byte_expected", 32'(expq.size() > 0), 1);
            if (expq.size() > 0) chk("byte_data", data_a[cur], expq[0]);
            if (pv && !pacc) chk("byte_stable_stalled", data_a[cur], pdata);
            if (rdy_a[cur]) begin
                got.push_back(data_a[cur]);
                if (expq.size() > 0) void'(expq.pop_front());
            end
        end
        if (done_a[cur]) chk("ss_n_high_at_done", ss_a[cur], 1);
        if (!busy_a[cur]) chk("ss_n_high_idle", ss_a[cur], 1);
        pv = valid_a[cur];
        pacc = valid_a[cur] && rdy_a[cur];
        pdata = data_a[cur];
    end

    task automatic xfer(input int idx, input logic [23:0] a, input int l, input int m, input bit restart);
        int  cyc, r0, n, dv;
        bit  ss_low, seen, restarted;
        cyc = 0; ss_low = 0; seen = 0; restarted = 0;
        cur = idx;
        mode = m;
        for (int i = 0; i < l; i++) expq.push_back(fb(a + 24'(i)));
        r0 = rises_a[idx];
        @(posedge clk); #1;
        start_a[idx] = 1'b1; addr_a[idx] = a; len_a[idx] = 16'(l);
        @(posedge clk); #1;
        start_a[idx] = 1'b0; addr_a[idx] = 24'($urandom); len_a[idx] = 16'($urandom);
        while (!seen && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!ss_a[idx]) ss_low = 1;
            if (restart && !restarted && rises_a[idx] - r0 > 40) begin
                restarted = 1;
                start_a[idx] = 1'b1;
            end else start_a[idx] = 1'b0;
            if (done_a[idx]) seen = 1;
        end
        chk("done_seen", 32'(seen), 1);
        chk("busy_with_done", busy_a[idx], 1);
        @(negedge clk);
        start_a[idx] = 1'b0;
        chk("busy_after_done", busy_a[idx], 0);
        chk("done_single_pulse", done_a[idx], 0);
        n = 32 + 8 * l;
        dv = (idx == 0) ? 2 : 1;
        chk("sck_rise_count", 32'(rises_a[idx] - r0), (l == 0) ? 0 : 32'(n));
        chk("ss_n_asserted", 32'(ss_low), 32'(l != 0));
        chk("bytes_remaining", 32'(expq.size()), 0);
        if (l == 0) chk("zero_len_latency", 32'(cyc), 1);
        else chk("mosi_cmd_addr", cmd_a[idx], {8'h03, a});
        if (m == 0 && l > 0) chk("duration_window", 32'(cyc >= 2 * dv * n && cyc <= 2 * dv * n + 4 * dv + 4), 1);
        if (m == 1) begin
            chk("stall_edge_count", 32'(stall_rises - r0), 47);
            chk("stall_sck_low", stall_sck, 0);
        end
        mode = 0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int r0, k;
        for (int i = 0; i < 2; i++) begin
            start_a[i] = 1'b0; addr_a[i] = '0; len_a[i] = '0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("reset_ss_n", ss_a[i], 1);
            chk("reset_sck", sck_a[i], 0);
            chk("reset_mosi", mosi_a[i], 0);
            chk("reset_busy", busy_a[i], 0);
            chk("reset_done", done_a[i], 0);
            chk("reset_valid", valid_a[i], 0);
            chk("reset_data", data_a[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        cmp_on = 1;
        repeat (2) @(posedge clk);

        xfer(0, 24'h012345, 4, 0, 0);
        chk("got_count", 32'(got.size()), 4);
        if (got.size() >= 4) begin
            chk("lit_byte0", got[0], 8'hA0);
            chk("lit_byte1", got[1], 8'hA1);
            chk("lit_byte2", got[2], 8'hA2);
            chk("lit_byte3", got[3], 8'hA3);
        end
        chk("lit_cmd_addr", cmd_a[0], 32'h0301_2345);

        xfer(0, 24'h012345, 4, 1, 0);
        xfer(0, 24'h00BEEF, 0, 0, 0);

        cur = 0;
        r0 = rises_a[0];
        @(posedge clk); #1;
        start_a[0] = 1'b1; addr_a[0] = 24'h123456; len_a[0] = 16'd4;
        @(posedge clk); #1;
        start_a[0] = 1'b0;
        k = 0;
        while (rises_a[0] - r0 < 16 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("reached_addr_phase", 32'(rises_a[0] - r0 >= 16), 1);
        #1 rst = 1'b1;
        #1;
        chk("midreset_ss_n", ss_a[0], 1);
        chk("midreset_sck", sck_a[0], 0);
        chk("midreset_busy", busy_a[0], 0);
        chk("midreset_mosi", mosi_a[0], 0);
        @(negedge clk);
        rst = 1'b0;
        xfer(0, 24'($urandom), 1, 0, 0);

        xfer(0, 24'h0ABCDE, 5, 0, 1);
        xfer(1, 24'($urandom), 256, 2, 0);
        xfer(1, 24'hFFFFFE, 4, 2, 0);
        for (int i = 0; i < 6; i++)
            xfer(i % 2, 24'($urandom), $urandom_range(1, 6), 2 * $urandom_range(0, 1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", ncmp, nerr + 1);
        $fatal(1, "watchdog");
    end
endmodule
